// File: rtl/nibble_xor_descrambler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nibble_xor_descrambler                                                   |
// | Additive 4-bit LFSR (x^4+x^3+1) descrambler with seeded, framed input.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module nibble_xor_descrambler #(
  parameter int FRAME_LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seed_load,
  input  logic [3:0] seed,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic       busy,
  output logic [7:0] nib_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] c_LAST_CNT = 8'(FRAME_LEN - 1);

  state_t     r_state;
  logic [3:0] r_lfsr;
  logic [7:0] r_nib_cnt;
  logic       r_out_valid;
  logic [3:0] r_out_data;

  logic       w_in_ready;
  logic       w_in_hs;
  logic       w_out_hs;
  logic [3:0] w_lfsr_next;
  logic [3:0] w_seed_legal;

  // in_valid is deliberately excluded so ready never depends on valid.
  assign w_in_ready   = (r_state == S_RUN) && (!r_out_valid || out_ready) && !seed_load;
  assign w_in_hs      = in_valid && w_in_ready;
  assign w_out_hs     = r_out_valid && out_ready;
  assign w_lfsr_next  = {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
  assign w_seed_legal = (seed == 4'b0000) ? 4'b0001 : seed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_lfsr      <= 4'b0001;
      r_nib_cnt   <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= 4'd0;
    end else if (seed_load) begin
      r_state     <= S_RUN;
      r_lfsr      <= w_seed_legal;
      r_nib_cnt   <= 8'd0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_in_hs) begin
            r_out_data  <= in_data ^ r_lfsr;
            r_out_valid <= 1'b1;
            r_lfsr      <= w_lfsr_next;
            r_nib_cnt   <= r_nib_cnt + 8'd1;
            if (r_nib_cnt == c_LAST_CNT) begin
              r_state <= S_DRAIN;
            end
          end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
          end
        end
        S_DRAIN: begin
          // Leave as soon as the last nibble has been (or is being) taken.
          if (!r_out_valid) begin
            r_state <= S_IDLE;
          end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state != S_IDLE);
  assign nib_cnt   = r_nib_cnt;

endmodule
`default_nettype wire

// File: tb/tb_nibble_xor_descrambler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nibble_xor_descrambler                                                |
// | Randomised bench against a keystream/queue reference model. Rev 1.0      |
// +--------------------------------------------------------------------------+
module tb_nibble_xor_descrambler;

  localparam int FL  = 16;
  localparam int FL4 = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       seed_load = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] seed = 4'd0, in_data = 4'd0;
  logic       in_ready, out_valid, busy;
  logic [3:0] out_data;
  logic [7:0] nib_cnt;

  logic       s4_load = 1'b0, s4_iv = 1'b0, s4_ordy = 1'b0;
  logic [3:0] s4_seed = 4'd0, s4_id = 4'd0;
  logic       s4_ir, s4_ov, s4_busy;
  logic [3:0] s4_od;
  logic [7:0] s4_cnt;

  nibble_xor_descrambler #(.FRAME_LEN(FL)) u_dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .nib_cnt(nib_cnt)
  );

  nibble_xor_descrambler #(.FRAME_LEN(FL4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .seed_load(s4_load), .seed(s4_seed),
    .in_valid(s4_iv), .in_ready(s4_ir), .in_data(s4_id),
    .out_valid(s4_ov), .out_ready(s4_ordy), .out_data(s4_od),
    .busy(s4_busy), .nib_cnt(s4_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Keystream nibble k of a frame: the seed (zero mapped to one) stepped k times.
  function automatic logic [3:0] ks(input logic [3:0] sd, input int k);
    logic [3:0] s;
    s = (sd == 4'd0) ? 4'd1 : sd;
    for (int i = 0; i < (k % 15); i++) s = {s[2:0], s[3] ^ s[2]};
    return s;
  endfunction

  // Reference model state
  logic [3:0] q[$];
  int         m_cnt  = 0;
  logic [3:0] m_seed = 4'd1;
  bit         m_run  = 1'b0;
  bit         m_busy = 1'b0;

  task automatic cyc(input bit sl, input logic [3:0] sd, input bit iv, input logic [3:0] id,
                     input bit ordy, output bit oh, output logic [3:0] od);
    bit exp_ir, ih, drain;
    @(negedge clk);
    seed_load = sl; seed = sd; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    exp_ir = m_run && !sl && (q.size() == 0 || ordy);
    ih     = iv && exp_ir;
    oh     = (q.size() != 0) && ordy;
    od     = out_data;
    check_eq("out_valid", out_valid, q.size() != 0);
    check_eq("in_ready", in_ready, exp_ir);
    check_eq("nib_cnt", nib_cnt, m_cnt);
    check_eq("busy", busy, m_busy);
    if (oh) check_eq("out_data", out_data, q[0]);
    drain = m_busy && !m_run;
    if (sl) begin
      q.delete(); m_cnt = 0; m_seed = sd; m_run = 1'b1; m_busy = 1'b1;
    end else begin
      if (drain && (q.size() == 0 || oh)) m_busy = 1'b0;
      if (oh) void'(q.pop_front());
      if (ih) begin
        q.push_back(id ^ ks(m_seed, m_cnt));
        m_cnt++;
        if (m_cnt == FL) m_run = 1'b0;
      end
    end
  endtask

  logic [3:0] outs[$];
  logic [3:0] c_exp6[6];
  bit         oh;
  logic [3:0] od;

  initial begin
    c_exp6 = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6};
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_out_data", out_data, 4'h0);
    rst_n = 1'b1;

    // In IDLE valid input is ignored
    cyc(0, 0, 1, 4'h5, 1, oh, od);

    // Zero data, seed 1: raw keystream, then seed 0 must give the same
    for (int s = 0; s < 2; s++) begin
      outs.delete();
      cyc(1, (s == 0) ? 4'd1 : 4'd0, 0, 0, 1, oh, od);
      for (int i = 0; i < 20; i++) begin
        cyc(0, 0, 1, 4'h0, 1, oh, od);
        if (oh) outs.push_back(od);
      end
      check_eq("ks_count", outs.size(), 16);
      if (outs.size() == 16) begin
        for (int i = 0; i < 6; i++) check_eq("ks_const", outs[i], c_exp6[i]);
        check_eq("ks_period", outs[15], 4'h1);
      end
    end

    // seed_load mid-frame with in_valid and a stalled output
    cyc(1, 4'h7, 0, 0, 1, oh, od);
    cyc(0, 0, 1, 4'hA, 0, oh, od);
    cyc(0, 0, 1, 4'hB, 0, oh, od);
    cyc(1, 4'hC, 1, 4'hD, 0, oh, od);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 4'(i), 1, oh, od);

    // Random frames with random backpressure and occasional reseeds
    for (int f = 0; f < 8; f++) begin
      cyc(1, 4'($urandom), 0, 0, 1, oh, od);
      for (int i = 0; i < 120 && m_busy; i++)
        cyc(($urandom_range(0, 59) == 0), 4'($urandom), $urandom_range(0, 3) != 0,
            4'($urandom), $urandom_range(0, 2) != 0, oh, od);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 4'($urandom), 1, oh, od);
    end

    // Asynchronous reset mid-frame with an output pending
    cyc(1, 4'h9, 0, 0, 0, oh, od);
    cyc(0, 0, 1, 4'h3, 0, oh, od);
    cyc(0, 0, 1, 4'h4, 0, oh, od);
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid, 1'b0);
    check_eq("arst_out_data", out_data, 4'h0);
    check_eq("arst_nib_cnt", nib_cnt, 8'd0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_in_ready", in_ready, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    q.delete(); m_cnt = 0; m_run = 1'b0; m_busy = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 4'h1, 1, oh, od);
    cyc(1, 4'h2, 0, 0, 1, oh, od);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 4'(i), 1, oh, od);
    cyc(0, 0, 0, 0, 0, oh, od);

    // FRAME_LEN=4 drain behaviour
    @(negedge clk);
    s4_load = 1'b1; s4_seed = 4'h5; s4_ordy = 1'b1;
    @(negedge clk);
    s4_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s4_iv = 1'b1; s4_id = 4'(i + 8);
      #1 check_eq("d4_in_ready", s4_ir, 1'b1);
      @(negedge clk);
    end
    s4_iv = 1'b1; s4_ordy = 1'b0;
    #1;
    check_eq("d4_busy", s4_busy, 1'b1);
    check_eq("d4_in_ready", s4_ir, 1'b0);
    check_eq("d4_nib_cnt", s4_cnt, 8'd4);
    check_eq("d4_out_valid", s4_ov, 1'b1);
    check_eq("d4_out_data", s4_od, 4'd11 ^ ks(4'h5, 3));
    @(negedge clk); #1;
    check_eq("d4_hold_busy", s4_busy, 1'b1);
    check_eq("d4_hold_data", s4_od, 4'd11 ^ ks(4'h5, 3));
    s4_ordy = 1'b1;
    @(negedge clk); #1;
    check_eq("d4_idle_busy", s4_busy, 1'b0);
    check_eq("d4_idle_ov", s4_ov, 1'b0);
    check_eq("d4_idle_cnt", s4_cnt, 8'd4);
    check_eq("d4_idle_ir", s4_ir, 1'b0);
    s4_iv = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nibble_xor_descrambler.md
NIBBLE_XOR_DESCRAMBLER -- requirements
Module: nibble_xor_descrambler

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16, meaning the number of nibbles accepted per seeded frame (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port seed_load, input, 1, a one-cycle request to load the seed and start a frame.
REQ-005 SHALL have port seed, input, 4, the LFSR seed, sampled when seed_load=1.
REQ-006 SHALL have port in_valid, input, 1, scrambled nibble valid.
REQ-007 SHALL have port in_ready, output, 1, block can accept a nibble.
REQ-008 SHALL have port in_data, input, 4, scrambled nibble.
REQ-009 SHALL have port out_valid, output, 1, descrambled nibble valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the nibble.
REQ-011 SHALL have port out_data, output, 4, descrambled nibble.
REQ-012 SHALL have port busy, output, 1, high in states RUN and DRAIN.
REQ-013 SHALL have port nib_cnt, output, 8, count of nibbles accepted in the current frame.

Function
REQ-014 SHALL implement a 4-bit Fibonacci LFSR, polynomial x^4+x^3+1; step: lfsr_next = {lfsr[2:0], lfsr[3]^lfsr[2]}; period 15.
REQ-015 SHALL replace a seed of 4'b0000 with 4'b0001 on load, because the all-zero state is illegal.
REQ-016 SHALL implement an additive descrambler: the keystream depends only on the seed and the count of accepted nibbles, never on the data.
REQ-017 SHALL use three FSM states: IDLE, RUN and DRAIN.
REQ-018 In IDLE, SHALL hold in_ready=0 and ignore in_valid.
REQ-019 seed_load=1 in any state SHALL load the LFSR from seed, clear nib_cnt, clear out_valid (flushing any pending output) and enter RUN on the next cycle.
REQ-020 seed_load SHALL take priority over an input handshake in the same cycle; that input nibble is not consumed.
REQ-021 In RUN, in_ready SHALL equal (!out_valid || out_ready) && !seed_load.
REQ-022 On an input handshake (in_valid && in_ready): out_data <= in_data ^ lfsr, out_valid <= 1, lfsr advances one step, nib_cnt increments; latency is 1 cycle.
REQ-023 On an output handshake with no new input, out_valid SHALL go to 0.
REQ-024 Simultaneous output and input handshakes SHALL sustain 1 nibble per clock with no bubble.
REQ-025 out_data and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 When the accepted nibble makes nib_cnt equal FRAME_LEN, the FSM SHALL go RUN->DRAIN; in DRAIN, in_ready=0.
REQ-027 In DRAIN, the FSM SHALL go to IDLE in the cycle after out_valid is cleared by an output handshake, or immediately if out_valid=0.
REQ-028 nib_cnt SHALL hold its final value in DRAIN and IDLE until the next seed_load.
REQ-029 in_ready SHALL be combinational from state, out_valid, out_ready and seed_load only, never from in_valid.

Reset
REQ-030 rst_n=0 SHALL asynchronously force: state=IDLE, lfsr=4'b0001, nib_cnt=0, out_valid=0, out_data=0, busy=0, in_ready=0.
REQ-031 Reset asserted mid-frame SHALL discard the pending output and any partial frame; a new seed_load is needed after release.
REQ-032 Reset release SHALL be synchronised by the integrator; no handshake is required in the first cycle after release.

Verification
REQ-033 Seed 4'b0001, FRAME_LEN=16, in_data=0000 continuously, out_ready=1 -> out_data=0001,0010,0100,1001,0011,0110, one per clock; the sequence repeats after 15 nibbles.
REQ-034 Round-trip: a reference scrambler with the same seed XORs random nibbles; the descrambler output SHALL match the original data across backpressure with random out_ready.
REQ-035 Seed 4'b0000 -> keystream identical to that of seed 4'b0001.
REQ-036 FRAME_LEN=4, out_ready=0 after the 4th accept -> state DRAIN, in_ready=0, nib_cnt=4; raise out_ready -> IDLE one cycle after the handshake, busy=0.
REQ-037 seed_load asserted with in_valid=1 and out_valid=1 mid-frame -> input not consumed, out_valid=0 next cycle, nib_cnt=0, keystream restarts from the new seed.
REQ-038 rst_n pulsed low mid-frame, asynchronously to clk -> outputs match REQ-030 immediately; in_ready=0 until seed_load.
